// File: rtl/mand_rr_scheduler_pkg.sv
// ============================================================================
// Module : mand_sched_pkg
// Brief  : Shared constants and types for the mand round-robin scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mand_sched_pkg;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;
endpackage

`default_nettype wire

// File: rtl/mand_rr_scheduler_if.sv
// ============================================================================
// Module : mand_rr_scheduler_if
// Brief  : Requester-side and response-side handshake bundle for the scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mand_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_a;
  logic [NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_data;
  logic               rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/mand.sv
// ============================================================================
// Module : mand
// Brief  : Shared 1-bit AND unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mand (
  input  wire logic a,
  input  wire logic b,
  output logic      y
);
  assign y = a & b;
endmodule

`default_nettype wire

// File: rtl/mand_rr_scheduler_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker: first set bit at or after ptr.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0]      grant,
  output logic [ID_W-1:0]         winner,
  output logic                    any
);
  logic [ID_W:0] idx;

  // Scan offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (req[idx[ID_W-1:0]]) begin
        winner = idx[ID_W-1:0];
        any    = 1'b1;
      end
    end
    grant = any ? (NUM_REQ'(1) << winner) : '0;
  end
endmodule

`default_nettype wire

// File: rtl/mand_rr_scheduler.sv
// ============================================================================
// Module : mand_rr_scheduler
// Brief  : Round-robin sharing of one mand unit; optional grant counters
//          enabled by MAND_RR_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mand_rr_scheduler
  import mand_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mand_rr_scheduler_if.slave bus
`ifdef MAND_RR_STATS_EN
  ,
  input  wire logic [ID_W-1:0] stat_sel,
  output logic [STAT_W-1:0]    stat_cnt
`endif
);
  out_state_e         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_data_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic               any;
  logic               can_accept;
  logic               accept;
  logic               mand_y;
  logic [ID_W-1:0]    ptr_next;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  mand u_mand (
    .a (bus.req_a[winner]),
    .b (bus.req_b[winner]),
    .y (mand_y)
  );

  assign can_accept    = (state == EMPTY) || bus.rsp_ready;
  assign accept        = rst && can_accept && any;
  assign bus.req_ready = accept ? grant : '0;
  assign ptr_next      = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      ptr        <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= 1'b0;
    end else if (accept) begin
      state      <= FULL;
      ptr        <= ptr_next;
      rsp_id_q   <= winner;
      rsp_data_q <= mand_y;
    end else if (state == FULL && bus.rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef MAND_RR_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst)
        grant_cnt[i] <= '0;
      else if (bus.req_ready[i] && grant_cnt[i] != STAT_MAX)
        grant_cnt[i] <= grant_cnt[i] + 1'b1;
    end
  end

  // Out-of-range selects (non power-of-two NUM_REQ) read as zero.
  always_comb begin
    stat_cnt = '0;
    if (32'(stat_sel) < NUM_REQ)
      stat_cnt = grant_cnt[stat_sel];
  end
`endif
endmodule

`default_nettype wire

// File: tb/tb_mand_rr_scheduler.sv
// ============================================================================
// Module : tb_mand_rr_scheduler
// Brief  : Directed self-checking bench for mand_rr_scheduler (NUM_REQ=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mand_rr_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mand_rr_scheduler_if #(.NUM_REQ(N)) bus ();

`ifdef MAND_RR_STATS_EN
  logic [1:0]  stat_sel = 2'd0;
  logic [15:0] stat_cnt;
`endif

  mand_rr_scheduler #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MAND_RR_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id, input logic d);
    check_eq({tag, ".valid"}, 32'(bus.rsp_valid), 32'(v));
    check_eq({tag, ".id"},    32'(bus.rsp_id),    32'(id));
    check_eq({tag, ".data"},  32'(bus.rsp_data),  32'(d));
  endtask

  logic [3:0] bpat;

  initial begin
    // Reset hold with every requester asking.
    bus.req_valid = 4'b1111;
    bus.req_a     = 4'b1111;
    bus.req_b     = 4'b1111;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check_eq("rst.ready", 32'(bus.req_ready), 32'h0);
    check_rsp("rst", 1'b0, 2'd0, 1'b0);
    check_eq("rst.ptr", 32'(dut.ptr), 32'd0);

    // Single request from requester 2.
    rst           = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_a     = 4'b0100;
    bus.req_b     = 4'b0100;
    bus.rsp_ready = 1'b1;
    settle();
    check_eq("single.ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 4'b0000;
    settle();
    check_rsp("single", 1'b1, 2'd2, 1'b1);
    check_eq("single.ptr", 32'(dut.ptr), 32'd3);
    check_eq("single.idle_ready", 32'(bus.req_ready), 32'h0);

    // Drain without refill keeps id/data.
    tick();
    check_rsp("drain", 1'b0, 2'd2, 1'b1);
    check_eq("drain.ptr", 32'(dut.ptr), 32'd3);

    // Requester 3 alone brings ptr back to 0 (wrap).
    bus.req_valid = 4'b1000;
    bus.req_a     = 4'b1000;
    bus.req_b     = 4'b0000;
    settle();
    check_eq("wrap3.ready", 32'(bus.req_ready), 32'b1000);
    tick();
    check_rsp("wrap3", 1'b1, 2'd3, 1'b0);
    check_eq("wrap3.ptr", 32'(dut.ptr), 32'd0);

    // Fairness: all valid, continuous drain -> grants 0,1,2,3,0.
    bpat          = 4'b0101;
    bus.req_valid = 4'b1111;
    bus.req_a     = 4'b1111;
    bus.req_b     = bpat;
    for (int k = 0; k < 5; k++) begin
      settle();
      check_eq($sformatf("rr%0d.ready", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check_rsp($sformatf("rr%0d", k), 1'b1, 2'(k % 4), bpat[k % 4]);
    end

    // Backpressure with requester 1 holding the register.
    settle();
    check_eq("bp.fill_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq($sformatf("bp%0d.ready", k), 32'(bus.req_ready), 32'h0);
      check_rsp($sformatf("bp%0d", k), 1'b1, 2'd1, 1'b0);
      check_eq($sformatf("bp%0d.ptr", k), 32'(dut.ptr), 32'd2);
      tick();
    end
    bus.rsp_ready = 1'b1;
    settle();
    check_eq("bp.release_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    check_rsp("bp.release", 1'b1, 2'd2, 1'b1);

    // Wrap/skip from ptr=3 with only 0 and 1 valid.
    bus.req_valid = 4'b0011;
    bus.req_a     = 4'b0011;
    bus.req_b     = 4'b0001;
    settle();
    check_eq("skip.ready0", 32'(bus.req_ready), 32'b0001);
    tick();
    check_rsp("skip0", 1'b1, 2'd0, 1'b1);
    check_eq("skip0.ptr", 32'(dut.ptr), 32'd1);
    check_eq("skip.ready1", 32'(bus.req_ready), 32'b0010);
    tick();
    check_rsp("skip1", 1'b1, 2'd1, 1'b0);
    check_eq("skip1.ptr", 32'(dut.ptr), 32'd2);

    // Load a 1 result, then reset mid-flight.
    bus.req_valid = 4'b0100;
    bus.req_a     = 4'b0100;
    bus.req_b     = 4'b0100;
    settle();
    check_eq("mid.ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    tick();
    check_rsp("mid.full", 1'b1, 2'd2, 1'b1);
`ifdef MAND_RR_STATS_EN
    stat_sel = 2'd2;
    settle();
    check_eq("stat.cnt2", 32'(stat_cnt), 32'd4);
    stat_sel = 2'd0;
    settle();
    check_eq("stat.cnt0", 32'(stat_cnt), 32'd3);
    stat_sel = 2'd3;
    settle();
    check_eq("stat.cnt3", 32'(stat_cnt), 32'd2);
`endif
    rst           = 1'b0;
    bus.req_valid = 4'b0110;
    bus.req_a     = 4'b0110;
    bus.req_b     = 4'b0010;
    settle();
    check_eq("mid.rst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check_rsp("mid.rst", 1'b0, 2'd0, 1'b0);
    check_eq("mid.rst_ptr", 32'(dut.ptr), 32'd0);
`ifdef MAND_RR_STATS_EN
    for (int i = 0; i < N; i++) begin
      stat_sel = 2'(i);
      settle();
      check_eq($sformatf("stat.clr%0d", i), 32'(stat_cnt), 32'd0);
    end
`endif
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    settle();
    check_eq("post.ready", 32'(bus.req_ready), 32'b0010);
    tick();
    check_rsp("post", 1'b1, 2'd1, 1'b1);
    check_eq("post.ptr", 32'(dut.ptr), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
